// File: rtl/rmsnorm_cmd_sequencer.sv
// Command sequencer for rmsnorm_engine: expands one batch descriptor into one
// engine command per row, walking src/dst by row_stride, with a per-row watchdog.
module rmsnorm_cmd_sequencer #(
  parameter int unsigned          TIMEOUT_W      = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [15:0] num_rows,
  input  logic [15:0] row_len,
  input  logic [15:0] src_base,
  input  logic [15:0] dst_base,
  input  logic [15:0] gamma_base,
  input  logic [15:0] row_stride,
  output logic        eng_cmd_valid,
  input  logic        eng_cmd_ready,
  output logic [15:0] eng_length,
  output logic [15:0] eng_src_base,
  output logic [15:0] eng_dst_base,
  output logic [15:0] eng_gamma_base,
  input  logic        eng_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rows_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Watchdog value during the last allowed S_WAIT cycle.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic [15:0]          rows_q, len_q, gamma_q, stride_q, src_q, dst_q;
  logic [15:0]          rows_done_q;
  logic                 err_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic                 wdog_hit;

  assign wdog_hit = (wdog_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          if (row_len == '0 || num_rows == '0) state_d = S_DONE;
          else                                 state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (eng_cmd_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done)      state_d = S_NEXT;
        else if (wdog_hit) state_d = S_DONE;
      end
      S_NEXT:  state_d = (rows_done_q == rows_q) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= '0;
      len_q       <= '0;
      gamma_q     <= '0;
      stride_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rows_done_q <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            rows_q      <= num_rows;
            len_q       <= row_len;
            gamma_q     <= gamma_base;
            stride_q    <= row_stride;
            src_q       <= src_base;
            dst_q       <= dst_base;
            rows_done_q <= '0;
            err_q       <= (row_len == '0);
          end
        end
        S_ISSUE: if (eng_cmd_ready) wdog_q <= '0;
        S_WAIT: begin
          // A done arriving on the timeout cycle takes priority over the error.
          if (eng_done)      rows_done_q <= rows_done_q + 16'd1;
          else if (wdog_hit) err_q       <= 1'b1;
          wdog_q <= wdog_q + TIMEOUT_W'(1);
        end
        S_NEXT: begin
          src_q <= src_q + stride_q;
          dst_q <= dst_q + stride_q;
        end
        default: ;
      endcase
    end
  end

  assign start_ready    = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign eng_cmd_valid  = (state_q == S_ISSUE);
  assign eng_length     = len_q;
  assign eng_src_base   = src_q;
  assign eng_dst_base   = dst_q;
  assign eng_gamma_base = gamma_q;
  assign err            = err_q;
  assign rows_done      = rows_done_q;

endmodule

// File: tb/tb_rmsnorm_cmd_sequencer.sv
// Bench for rmsnorm_cmd_sequencer: a behavioural engine answers commands while
// a scoreboard of expected commands is checked against every handshake.
module tb_rmsnorm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] num_rows, row_len, src_base, dst_base, gamma_base, row_stride;
  logic        eng_cmd_valid;
  logic        eng_cmd_ready;
  logic [15:0] eng_length, eng_src_base, eng_dst_base, eng_gamma_base;
  logic        eng_done;
  logic        busy, done, err;
  logic [15:0] rows_done;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] gamma;
  } cmd_t;

  cmd_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  rmsnorm_cmd_sequencer #(
    .TIMEOUT_W     (20),
    .TIMEOUT_CYCLES(20'd16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .num_rows      (num_rows),
    .row_len       (row_len),
    .src_base      (src_base),
    .dst_base      (dst_base),
    .gamma_base    (gamma_base),
    .row_stride    (row_stride),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_cmd_ready (eng_cmd_ready),
    .eng_length    (eng_length),
    .eng_src_base  (eng_src_base),
    .eng_dst_base  (eng_dst_base),
    .eng_gamma_base(eng_gamma_base),
    .eng_done      (eng_done),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rows_done     (rows_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Drives one descriptor for one cycle and pushes the commands it should produce.
  // Returns at the negedge after the accepting posedge.
  task automatic start_batch(input int rows, input logic [15:0] len, input logic [15:0] src,
                             input logic [15:0] dst, input logic [15:0] gamma,
                             input logic [15:0] stride);
    cmd_t c;
    @(negedge clk);
    num_rows = 16'(rows); row_len = len; src_base = src; dst_base = dst;
    gamma_base = gamma; row_stride = stride; start_valid = 1'b1;
    if (len != 16'd0) begin
      for (int i = 0; i < rows; i++) begin
        c.len   = len;
        c.src   = 16'(32'(src) + i * 32'(stride));
        c.dst   = 16'(32'(dst) + i * 32'(stride));
        c.gamma = gamma;
        exp_q.push_back(c);
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Engine model: holds ready low for `hold` cycles per command (optionally pulsing
  // a spurious done meanwhile), answers done `lat` cycles after accept (-1 = never).
  task automatic run_engine(input int lat, input int hold, input bit spur,
                            output int ncmd, output int done_c, output int hs_c,
                            output logic err_at_done);
    int   cd, held, rd_exp;
    bit   fin;
    cmd_t e, snap, cur;
    cd = -1; held = 0; rd_exp = 0; fin = 0; snap = '0;
    ncmd = 0; done_c = -1; hs_c = -1; err_at_done = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      eng_done = 1'b0;
      total++;
      if (rows_done !== 16'(rd_exp)) begin
        bad++;
        $display("FAIL rows_done: got %0d expected %0d (cycle %0d)", rows_done, rd_exp, c);
      end
      if (done) begin
        fin = 1; done_c = c; err_at_done = err;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_done = 1'b1; cd = -1; rd_exp++;
        end
      end
      cur = {eng_length, eng_src_base, eng_dst_base, eng_gamma_base};
      if (eng_cmd_valid && !fin) begin
        if (held == 0) snap = cur;
        else begin
          total++;
          if (cur !== snap) begin
            bad++;
            $display("FAIL payload_stable: got %h expected %h", cur, snap);
          end
        end
        if (held < hold) begin
          eng_cmd_ready = 1'b0; held++;
          if (spur) eng_done = 1'b1;
        end else begin
          eng_cmd_ready = 1'b1; held = 0; ncmd++; hs_c = c; cd = lat;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cmd: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              bad++;
              $display("FAIL cmd_payload: got %h expected %h", cur, e);
            end
          end
        end
      end else begin
        eng_cmd_ready = 1'b0;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL batch_timeout: got no done expected done");
    end
    eng_done = 1'b0;
    eng_cmd_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({start_ready, busy, done, err, eng_cmd_valid} !== 5'b10000 || rows_done !== 16'd0 ||
        {eng_length, eng_src_base, eng_dst_base, eng_gamma_base} !== 64'd0) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b busy=%b done=%b err=%b v=%b rows=%0d expected 1 0 0 0 0 0",
               start_ready, busy, done, err, eng_cmd_valid, rows_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int ncmd, dc, hc; logic e;
    start_batch(3, 16'd64, 16'h0100, 16'h0800, 16'h0000, 16'h0040);
    total++;
    if (eng_cmd_valid !== 1'b1) begin
      bad++; $display("FAIL start_to_valid: got %b expected 1", eng_cmd_valid);
    end
    run_engine(3, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 3 || e !== 1'b0 || dc - hc != 5) begin
      bad++;
      $display("FAIL nominal: got cmds=%0d err=%b lat=%0d expected 3 0 5", ncmd, e, dc - hc);
    end
  endtask

  task automatic test_backpressure;
    int ncmd, dc, hc; logic e;
    start_batch(2, 16'd32, 16'h2000, 16'h3000, 16'h0010, 16'h0100);
    run_engine(2, 5, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 2 || e !== 1'b0) begin
      bad++; $display("FAIL backpressure: got cmds=%0d err=%b expected 2 0", ncmd, e);
    end
  endtask

  task automatic test_degenerate;
    int ncmd, dc, hc; logic e;
    start_batch(0, 16'd64, 16'h0100, 16'h0200, 16'h0300, 16'h0040);
    run_engine(2, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 0 || dc != 0 || e !== 1'b0) begin
      bad++; $display("FAIL zero_rows: got cmds=%0d done_at=%0d err=%b expected 0 0 0", ncmd, dc, e);
    end
    start_batch(2, 16'd0, 16'h0100, 16'h0200, 16'h0300, 16'h0040);
    run_engine(2, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 0 || dc != 0 || e !== 1'b1) begin
      bad++; $display("FAIL zero_len: got cmds=%0d done_at=%0d err=%b expected 0 0 1", ncmd, dc, e);
    end
  endtask

  task automatic test_wrap_spurious;
    int ncmd, dc, hc; logic e;
    start_batch(2, 16'd16, 16'hFFC0, 16'h7FC0, 16'h0400, 16'h0040);
    total++;
    if (exp_q[1].src !== 16'h0000 || exp_q[1].dst !== 16'h8000) begin
      bad++; $display("FAIL wrap_model: got %h/%h expected 0000/8000", exp_q[1].src, exp_q[1].dst);
    end
    run_engine(4, 3, 1, ncmd, dc, hc, e);
    total++;
    if (ncmd != 2 || e !== 1'b0) begin
      bad++; $display("FAIL wrap: got cmds=%0d err=%b expected 2 0", ncmd, e);
    end
  endtask

  task automatic test_watchdog;
    int ncmd, dc, hc; logic e;
    start_batch(2, 16'd8, 16'h0000, 16'h1000, 16'h0000, 16'h0010);
    run_engine(-1, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 1 || e !== 1'b1 || dc - hc != 17) begin
      bad++;
      $display("FAIL watchdog: got cmds=%0d err=%b lat=%0d expected 1 1 17", ncmd, e, dc - hc);
    end
    total++;
    if (exp_q.size() != 1) begin
      bad++; $display("FAIL watchdog_left: got %0d expected 1", exp_q.size());
    end
    exp_q.delete();
    start_batch(1, 16'd8, 16'h0500, 16'h0600, 16'h0000, 16'h0010);
    run_engine(16, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 1 || e !== 1'b0 || dc - hc != 18) begin
      bad++;
      $display("FAIL done_wins: got cmds=%0d err=%b lat=%0d expected 1 0 18", ncmd, e, dc - hc);
    end
  endtask

  task automatic test_reset_mid;
    int ncmd, dc, hc; logic e;
    start_batch(4, 16'd64, 16'h4000, 16'h5000, 16'h0020, 16'h0080);
    eng_cmd_ready = 1'b1;
    @(negedge clk); eng_cmd_ready = 1'b0; eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    @(negedge clk); eng_cmd_ready = 1'b1;
    @(negedge clk); eng_cmd_ready = 1'b0;
    total++;
    if (rows_done !== 16'd1 || busy !== 1'b1 || eng_cmd_valid !== 1'b0) begin
      bad++; $display("FAIL mid_setup: got rows=%0d busy=%b v=%b expected 1 1 0",
                      rows_done, busy, eng_cmd_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({start_ready, busy, done, err, eng_cmd_valid} !== 5'b10000 || rows_done !== 16'd0 ||
        {eng_length, eng_src_base, eng_dst_base, eng_gamma_base} !== 64'd0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b err=%b v=%b rows=%0d expected 1 0 0 0 0 0",
               start_ready, busy, done, err, eng_cmd_valid, rows_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL reset_no_done: got %b expected 0", done);
      end
    end
    rst_n = 1'b1;
    exp_q.delete();
    start_batch(2, 16'd64, 16'h4000, 16'h5000, 16'h0020, 16'h0080);
    run_engine(2, 0, 0, ncmd, dc, hc, e);
    total++;
    if (ncmd != 2 || e !== 1'b0) begin
      bad++; $display("FAIL after_reset: got cmds=%0d err=%b expected 2 0", ncmd, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; eng_cmd_ready = 1'b0; eng_done = 1'b0;
    num_rows = '0; row_len = '0; src_base = '0; dst_base = '0;
    gamma_base = '0; row_stride = '0;
    test_reset;
    test_nominal;
    test_backpressure;
    test_degenerate;
    test_wrap_spurious;
    test_watchdog;
    test_reset_mid;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
